// File: rtl/taillight_pkg.sv
// Shared types and helpers for the tail-light sequencer.
// The sweep pattern is built wide here and narrowed to the lamp count by the caller.
package taillight_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } tl_mode_t;

    localparam int MAX_LAMPS = 32;

    // Pattern for sweep step k: the k lowest bits set, innermost lamp first.
    function automatic logic [MAX_LAMPS-1:0] sweep_mask(input int k);
        logic [MAX_LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LAMPS; i++) begin
            if (i < k) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/taillight_seq_if.sv
// Switch inputs and lamp outputs of the tail-light sequencer, plus a debug view of the mode.
// All request inputs are plain levels; there is no valid/ready handshake on this bus.
interface taillight_seq_if #(parameter int LAMPS = 3);
    import taillight_pkg::*;

    logic             left;
    logic             right;
    logic             hazard;
    logic             brake;
    logic [LAMPS-1:0] lamp_l;
    logic [LAMPS-1:0] lamp_r;
    logic             busy;
    tl_mode_t         dbg_mode;

    modport master (
        output left, right, hazard, brake,
        input  lamp_l, lamp_r, busy, dbg_mode
    );

    modport slave (
        input  left, right, hazard, brake,
        output lamp_l, lamp_r, busy, dbg_mode
    );

endinterface

// File: rtl/taillight_seq_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 and flags the last count as a sweep tick.
module tick_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // With TICK_DIV=1 the count never leaves 0, so tick is permanently high.
    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/taillight_seq.sv
// Turn / hazard / brake tail-light sequencer with inside-to-outside sweep.
// Lamps and busy are registered from the decode of the next mode/step and brake.
module taillight_seq
    import taillight_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic           clk,
    input  logic           reset,
    taillight_seq_if.slave bus
);

    localparam int SW = $clog2(LAMPS + 1);

    if (LAMPS < 2)          begin : g_chk_lamps   $error("LAMPS must be >= 2");        end
    if (LAMPS > MAX_LAMPS)  begin : g_chk_lampmax $error("LAMPS exceeds MAX_LAMPS");   end
    if (TICK_DIV < 1)       begin : g_chk_div     $error("TICK_DIV must be >= 1");     end

    logic             tick;
    tl_mode_t         mode_q, mode_d;
    logic [SW-1:0]    step_q, step_d;
    logic [LAMPS-1:0] lamp_l_d, lamp_r_d, sweep, brake_pat;
    logic             busy_d;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign bus.dbg_mode = mode_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= IDLE;
            step_q <= '0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end

    // Requests are only looked at from IDLE; a running sweep always finishes.
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            case (mode_q)
                IDLE: begin
                    if (bus.hazard || (bus.left && bus.right)) begin
                        mode_d = HAZ;   step_d = SW'(1);
                    end else if (bus.left) begin
                        mode_d = LEFT;  step_d = SW'(1);
                    end else if (bus.right) begin
                        mode_d = RIGHT; step_d = SW'(1);
                    end else begin
                        mode_d = IDLE;  step_d = '0;
                    end
                end
                LEFT, RIGHT, HAZ: begin
                    if (step_q == SW'(LAMPS)) begin
                        mode_d = IDLE;
                        step_d = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                default: begin
                    mode_d = IDLE;
                    step_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        sweep     = LAMPS'(sweep_mask(int'(step_d)));
        brake_pat = bus.brake ? {LAMPS{1'b1}} : '0;
        lamp_l_d  = '0;
        lamp_r_d  = '0;
        busy_d    = 1'b0;
        case (mode_d)
            IDLE: begin
                lamp_l_d = brake_pat;
                lamp_r_d = brake_pat;
            end
            LEFT: begin
                lamp_l_d = sweep;
                lamp_r_d = brake_pat;
                busy_d   = 1'b1;
            end
            RIGHT: begin
                lamp_l_d = brake_pat;
                lamp_r_d = sweep;
                busy_d   = 1'b1;
            end
            HAZ: begin
                lamp_l_d = sweep;
                lamp_r_d = sweep;
                busy_d   = 1'b1;
            end
            default: begin
                lamp_l_d = '0;
                lamp_r_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.lamp_l <= '0;
            bus.lamp_r <= '0;
            bus.busy   <= 1'b0;
        end else begin
            bus.lamp_l <= lamp_l_d;
            bus.lamp_r <= lamp_r_d;
            bus.busy   <= busy_d;
        end
    end

endmodule
